// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: timed highway/country/pedestrian phase FSM; EMERGENCY_PREEMPT_EN adds preempt input and S_PRE
module traffic_phase_scheduler #(
  parameter int Y2R_DELAY      = 3,
  parameter int R2G_DELAY      = 2,
  parameter int HWY_MIN_GREEN  = 8,
  parameter int CTRY_MAX_GREEN = 10,
  parameter int WALK_TIME      = 6,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       X,
  input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       preempt,
`endif
  output logic [1:0] highway,
  output logic [1:0] country,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {S_HG, S_HY, S_AR1, S_CG, S_CY, S_AR2, S_WALK, S_PRE} state_t;
  localparam logic [CNT_W-1:0] L_HG   = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] L_Y    = CNT_W'(Y2R_DELAY - 1);
  localparam logic [CNT_W-1:0] L_AR   = CNT_W'(R2G_DELAY - 1);
  localparam logic [CNT_W-1:0] L_CG   = CNT_W'(CTRY_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] L_WALK = CNT_W'(WALK_TIME - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             ped_q, ped_d, pre, expired;
`ifdef EMERGENCY_PREEMPT_EN
  assign pre = preempt;
`else
  assign pre = 1'b0;
`endif
  function automatic logic [CNT_W-1:0] load(input state_t s);
    return s == S_HG ? L_HG :
           (s == S_HY || s == S_CY) ? L_Y :
           s == S_CG ? L_CG :
           s == S_WALK ? L_WALK : L_AR;
  endfunction
  always_comb begin
    expired = tmr_q == '0;
    state_d = state_q;
    ped_d   = ped_q | ped_req;
    case (state_q)
      S_HG:   if (pre || (expired && (X || ped_q))) state_d = S_HY;
      S_HY:   if (expired) state_d = S_AR1;
      S_AR1:  if (expired) state_d = pre ? S_PRE : X ? S_CG : ped_q ? S_WALK : S_HG;
      S_CG:   if (pre || !X || expired) state_d = S_CY;
      S_CY:   if (expired) state_d = S_AR2;
      S_AR2:  if (expired) state_d = pre ? S_PRE : ped_q ? S_WALK : S_HG;
      S_WALK: if (pre) state_d = S_PRE; else if (expired) state_d = S_HG;
`ifdef EMERGENCY_PREEMPT_EN
      default: if (!pre && expired) state_d = S_HG;
`else
      default: state_d = S_HG;
`endif
    endcase
    if (state_d == S_WALK && state_q != S_WALK) ped_d = ped_req;
    if (state_q == S_WALK && pre) ped_d = 1'b1;
    tmr_d = (state_d != state_q || (state_q == S_PRE && pre)) ? load(state_d) :
            expired ? tmr_q : tmr_q - 1'b1;
    if (clear) begin
      state_d = S_HG;
      tmr_d   = L_HG;
      ped_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    tmr_q   <= tmr_d;
    ped_q   <= ped_d;
  end
  assign highway     = state_q == S_HG ? 2'd2 : state_q == S_HY ? 2'd1 : 2'd0;
  assign country     = state_q == S_CG ? 2'd2 : state_q == S_CY ? 2'd1 : 2'd0;
  assign walk        = state_q == S_WALK;
  assign ped_pending = ped_q;
  assign state_dbg   = state_q;
endmodule
